vga_square_scheduler: RTL and testbench

Sequences the shared VGA pixel-write port between the two drawing sources of the Simon Says game: the auto-playback engine and the manual (player-input) engine. Each source requests a filled square of one colour at a given origin. The block arbitrates between them and walks a pixel counter across the square. It drives the plotter one pixel per clock with a registered x/y/colour/plot bundle, sitting directly in front of the VGA adapter. The `stop` input keeps its game meaning: 0 = auto playback phase, 1 = player phase.

---
 rtl/vga_square_scheduler.sv | 141 ++++++++++++++
 tb/tb_vga_square_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_square_scheduler.sv
// Arbitrates the auto and manual drawing sources onto one VGA pixel-write port
// and scans a filled 2^SIDE_LOG2 square, one registered pixel per clock.
module vga_square_scheduler #(
  parameter int SIDE_LOG2 = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       stop,
  input  logic       auto_req,
  input  logic [7:0] auto_x,
  input  logic [6:0] auto_y,
  input  logic [2:0] auto_color,
  output logic       auto_ack,
  output logic       auto_done,
  input  logic       manual_req,
  input  logic [7:0] manual_x,
  input  logic [6:0] manual_y,
  input  logic [2:0] manual_color,
  output logic       manual_ack,
  output logic       manual_done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic       plot,
  output logic       busy
);

  localparam int CW = 2 * SIDE_LOG2;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic [7:0]      ox_q, ox_d;
  logic [6:0]      oy_q, oy_d;
  logic [2:0]      col_q, col_d;
  logic [7:0]      x_out_q, x_out_d;
  logic [6:0]      y_out_q, y_out_d;
  logic [2:0]      color_out_q, color_out_d;
  logic            plot_q, plot_d;
  logic            auto_ack_q, auto_ack_d;
  logic            manual_ack_q, manual_ack_d;
  logic            auto_done_q, auto_done_d;
  logic            manual_done_q, manual_done_d;
  logic            grant_manual;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    ox_d          = ox_q;
    oy_d          = oy_q;
    col_d         = col_q;
    x_out_d       = x_out_q;
    y_out_d       = y_out_q;
    color_out_d   = color_out_q;
    plot_d        = plot_q;
    auto_ack_d    = 1'b0;
    manual_ack_d  = 1'b0;
    auto_done_d   = 1'b0;
    manual_done_d = 1'b0;
    // owner_q: 0 = auto, 1 = manual; stop picks the winner only on a tie
    grant_manual  = manual_req && (!auto_req || stop);

    case (state_q)
      IDLE: begin
        if (auto_req || manual_req) begin
          owner_d      = grant_manual;
          ox_d         = grant_manual ? manual_x     : auto_x;
          oy_d         = grant_manual ? manual_y     : auto_y;
          col_d        = grant_manual ? manual_color : auto_color;
          cnt_d        = '0;
          auto_ack_d   = !grant_manual;
          manual_ack_d = grant_manual;
          state_d      = DRAW;
        end
      end
      DRAW: begin
        x_out_d     = ox_q + 8'(cnt_q[SIDE_LOG2-1:0]);
        y_out_d     = oy_q + 7'(cnt_q[CW-1:SIDE_LOG2]);
        color_out_d = col_q;
        plot_d      = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = DONE;
      end
      DONE: begin
        plot_d        = 1'b0;
        auto_done_d   = !owner_q;
        manual_done_d = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      ox_q          <= '0;
      oy_q          <= '0;
      col_q         <= '0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      color_out_q   <= '0;
      plot_q        <= 1'b0;
      auto_ack_q    <= 1'b0;
      manual_ack_q  <= 1'b0;
      auto_done_q   <= 1'b0;
      manual_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      col_q         <= col_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      color_out_q   <= color_out_d;
      plot_q        <= plot_d;
      auto_ack_q    <= auto_ack_d;
      manual_ack_q  <= manual_ack_d;
      auto_done_q   <= auto_done_d;
      manual_done_q <= manual_done_d;
    end
  end

  assign x_out       = x_out_q;
  assign y_out       = y_out_q;
  assign color_out   = color_out_q;
  assign plot        = plot_q;
  assign auto_ack    = auto_ack_q;
  assign manual_ack  = manual_ack_q;
  assign auto_done   = auto_done_q;
  assign manual_done = manual_done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vga_square_scheduler.sv
// Directed bench for vga_square_scheduler: default 8x8 instance plus a 2x2 instance
// sharing the same inputs.
module tb_vga_square_scheduler;

  logic       clock = 1'b0;
  logic       resetn;
  logic       stop;
  logic       auto_req, manual_req;
  logic [7:0] auto_x, manual_x;
  logic [6:0] auto_y, manual_y;
  logic [2:0] auto_color, manual_color;

  logic       auto_ack, auto_done, manual_ack, manual_done, plot, busy;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] color_out;

  logic       auto_ack1, auto_done1, manual_ack1, manual_done1, plot1, busy1;
  logic [7:0] x_out1;
  logic [6:0] y_out1;
  logic [2:0] color_out1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  vga_square_scheduler #(.SIDE_LOG2(3)) dut (
    .clock(clock), .resetn(resetn), .stop(stop),
    .auto_req(auto_req), .auto_x(auto_x), .auto_y(auto_y), .auto_color(auto_color),
    .auto_ack(auto_ack), .auto_done(auto_done),
    .manual_req(manual_req), .manual_x(manual_x), .manual_y(manual_y),
    .manual_color(manual_color), .manual_ack(manual_ack), .manual_done(manual_done),
    .x_out(x_out), .y_out(y_out), .color_out(color_out), .plot(plot), .busy(busy)
  );

  vga_square_scheduler #(.SIDE_LOG2(1)) dut1 (
    .clock(clock), .resetn(resetn), .stop(stop),
    .auto_req(auto_req), .auto_x(auto_x), .auto_y(auto_y), .auto_color(auto_color),
    .auto_ack(auto_ack1), .auto_done(auto_done1),
    .manual_req(manual_req), .manual_x(manual_x), .manual_y(manual_y),
    .manual_color(manual_color), .manual_ack(manual_ack1), .manual_done(manual_done1),
    .x_out(x_out1), .y_out(y_out1), .color_out(color_out1), .plot(plot1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called just after the grant edge has been sampled; walks E1..E(N+1).
  task automatic draw_check(input string tag, input logic [7:0] ox, input logic [6:0] oy,
                            input logic [2:0] col, input logic man, input logic scramble,
                            input logic with1);
    logic [7:0] xe;
    logic [6:0] ye;
    for (int k = 0; k < 64; k++) begin
      step();
      xe = ox + 8'(k % 8);
      ye = oy + 7'(k / 8);
      chk({tag, "_plot"}, {31'd0, plot}, 1);
      chk({tag, "_x"}, {24'd0, x_out}, {24'd0, xe});
      chk({tag, "_y"}, {25'd0, y_out}, {25'd0, ye});
      chk({tag, "_col"}, {29'd0, color_out}, {29'd0, col});
      chk({tag, "_ackdone"}, {28'd0, auto_ack, manual_ack, auto_done, manual_done}, 0);
      if (with1 && k < 4) begin
        chk({tag, "_s1_plot"}, {31'd0, plot1}, 1);
        chk({tag, "_s1_x"}, {24'd0, x_out1}, {24'd0, ox + 8'(k % 2)});
        chk({tag, "_s1_y"}, {25'd0, y_out1}, {25'd0, oy + 7'(k / 2)});
      end
      if (with1 && k == 4) begin
        chk({tag, "_s1_done"}, {31'd0, auto_done1}, 1);
        chk({tag, "_s1_plot0"}, {31'd0, plot1}, 0);
      end
      if (scramble && k == 10) begin
        stop = ~stop;
        auto_x = ~auto_x;   auto_y = ~auto_y;   auto_color = ~auto_color;
        manual_x = ~manual_x; manual_y = ~manual_y; manual_color = ~manual_color;
      end
    end
    step();
    chk({tag, "_done_plot"}, {31'd0, plot}, 0);
    chk({tag, "_done"}, {30'd0, auto_done, manual_done}, man ? 32'd1 : 32'd2);
    chk({tag, "_done_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done_noack"}, {30'd0, auto_ack, manual_ack}, 0);
  endtask

  initial begin
    int cyc;
    int md_at;
    logic seen;

    resetn = 1'b0; stop = 1'b0;
    auto_req = 1'b0; auto_x = '0; auto_y = '0; auto_color = '0;
    manual_req = 1'b0; manual_x = '0; manual_y = '0; manual_color = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outs", {x_out, y_out, color_out, plot, busy, auto_ack, auto_done,
                     manual_ack, manual_done}, 0);
    resetn = 1'b1;
    step();
    chk("idle_busy", {31'd0, busy}, 0);

    // Basic auto square, both instances
    auto_req = 1'b1; auto_x = 8'd10; auto_y = 7'd20; auto_color = 3'b100;
    step();
    chk("t1_ack", {30'd0, auto_ack, manual_ack}, 2);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_plot0", {31'd0, plot}, 0);
    chk("t1_s1_ack", {31'd0, auto_ack1}, 1);
    auto_req = 1'b0;
    draw_check("t1", 8'd10, 7'd20, 3'd4, 1'b0, 1'b0, 1'b1);
    step();
    chk("t1_done_pulse", {31'd0, auto_done}, 0);

    // Simultaneous requests, stop=1: manual first, auto 66 cycles later
    stop = 1'b1;
    auto_req = 1'b1;   auto_x = 8'd30;   auto_y = 7'd40;   auto_color = 3'd1;
    manual_req = 1'b1; manual_x = 8'd50; manual_y = 7'd60; manual_color = 3'd2;
    step();
    chk("t2_first", {30'd0, auto_ack, manual_ack}, 1);
    manual_req = 1'b0;
    cyc = 0; md_at = 0;
    while (!auto_ack && cyc < 100) begin
      step();
      cyc++;
      if (manual_done) md_at = cyc;
    end
    chk("t2_gap", cyc, 66);
    chk("t2_mdone_at", md_at, 65);
    auto_req = 1'b0;
    draw_check("t2a", 8'd30, 7'd40, 3'd1, 1'b0, 1'b1, 1'b0);

    // Same with stop=0: auto first
    step();
    stop = 1'b0;
    auto_req = 1'b1;   auto_x = 8'd1;    auto_y = 7'd2;    auto_color = 3'd3;
    manual_req = 1'b1; manual_x = 8'd70; manual_y = 7'd80; manual_color = 3'd5;
    step();
    chk("t3_first", {30'd0, auto_ack, manual_ack}, 2);
    auto_req = 1'b0;
    cyc = 0;
    while (!manual_ack && cyc < 100) begin
      step();
      cyc++;
    end
    chk("t3_gap", cyc, 66);
    manual_req = 1'b0;
    draw_check("t3m", 8'd70, 7'd80, 3'd5, 1'b1, 1'b0, 1'b0);

    // Wrapping origin, no clipping
    step();
    manual_req = 1'b1; manual_x = 8'd252; manual_y = 7'd124; manual_color = 3'd6;
    step();
    chk("t4_ack", {31'd0, manual_ack}, 1);
    manual_req = 1'b0;
    draw_check("t4w", 8'd252, 7'd124, 3'd6, 1'b1, 1'b0, 1'b0);

    // Reset at pixel 30: abandoned, no done
    step();
    auto_req = 1'b1; auto_x = 8'd5; auto_y = 7'd6; auto_color = 3'd7;
    step();
    chk("t5_ack", {31'd0, auto_ack}, 1);
    auto_req = 1'b0;
    repeat (30) step();
    chk("t5_midplot", {31'd0, plot}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_rst", {x_out, y_out, color_out, plot, busy, auto_ack, auto_done,
                         manual_ack, manual_done}, 0);
    @(negedge clock);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      seen = seen | auto_done | plot;
    end
    chk("t5_no_done", {31'd0, seen}, 0);
    auto_req = 1'b1; auto_x = 8'd0; auto_y = 7'd0; auto_color = 3'd2;
    step();
    chk("t5_regrant", {31'd0, auto_ack}, 1);
    auto_req = 1'b0;
    draw_check("t5n", 8'd0, 7'd0, 3'd2, 1'b0, 1'b0, 1'b0);

    // Req held through done, inputs scrambled mid-draw
    step();
    stop = 1'b0;
    auto_req = 1'b1; auto_x = 8'd100; auto_y = 7'd50; auto_color = 3'd3;
    step();
    chk("t6_ack", {31'd0, auto_ack}, 1);
    draw_check("t6", 8'd100, 7'd50, 3'd3, 1'b0, 1'b1, 1'b0);
    step();
    chk("t6_reack", {30'd0, auto_ack, manual_ack}, 2);
    auto_req = 1'b0;
    cyc = 0;
    while (!auto_done && cyc < 100) begin
      step();
      cyc++;
    end
    chk("t6_second_done_at", cyc, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
